// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU memory arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester owns the in-flight transaction
//   XLEN        : native data width of the core
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_DATA,
    OWN_FETCH
  } owner_t;

endpackage

// File: rtl/arb_timeout_timer.sv
// Transaction watchdog for the memory arbiter.
//   clk, rst : clock, synchronous active-high reset
//   load     : restart the count at zero (issued as a transaction is launched)
//   count    : advance one step (asserted every cycle spent in REQ or RESP)
//   expire   : this counted cycle is the TIMEOUT_CYC-th one
module arb_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (count && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = count && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch port (i_*)
// and the data port (d_*). One transaction in flight, Moore outputs.
//   d_req/d_we/d_addr/d_wdata/d_wstrb : data request, held until d_done
//   d_done/d_err/d_rdata              : data completion pulse, timeout flag, read data
//   i_req/i_addr                      : fetch request, held until i_done
//   i_done/i_err/i_rdata              : fetch completion pulse, timeout flag, instruction
//   mem_req/we/addr/wdata/wstrb       : memory request, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata    : memory accept, completion, read data
// Data wins ties; after STARVE_LIMIT consecutive data wins over a pending
// fetch, the fetch is forced through.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = XLEN,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT_CYC  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_done,
  output logic            d_err,
  output logic [DW-1:0]   d_rdata,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_done,
  output logic            i_err,
  output logic [DW-1:0]   i_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t      state_q, state_d;
  owner_t          owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic tmr_load, tmr_count, tmr_expire;

  arb_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .count (tmr_count),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    starve_d  = starve_q;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          tmr_load = 1'b1;
          state_d  = REQ;
          if (i_req && (!d_req || (starve_q == STARVE_MAX))) begin
            owner_d  = OWN_FETCH;
            we_d     = 1'b0;
            addr_d   = i_addr;
            wdata_d  = '0;
            wstrb_d  = '0;
            starve_d = '0;
          end else begin
            owner_d = OWN_DATA;
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            // strobes only carry meaning on writes
            wstrb_d = d_we ? d_wstrb : '0;
            if (i_req && (starve_q != STARVE_MAX)) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end
      REQ: begin
        tmr_count = 1'b1;
        // a grant landing on the expiry cycle is abandoned; its rvalid
        // arrives while we are no longer in RESP and is dropped
        if (tmr_expire) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (mem_gnt) begin
          state_d = RESP;
        end
      end
      RESP: begin
        tmr_count = 1'b1;
        if (mem_rvalid) begin
          state_d = DONE;
          err_d   = 1'b0;
          rdata_d = mem_rdata;
        end else if (tmr_expire) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_DATA;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  assign d_done  = (state_q == DONE) && (owner_q == OWN_DATA);
  assign i_done  = (state_q == DONE) && (owner_q == OWN_FETCH);
  assign d_err   = d_done && err_q;
  assign i_err   = i_done && err_q;
  assign d_rdata = rdata_q;
  assign i_rdata = rdata_q;

endmodule
